// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache. Lookups hit combinationally in the same cycle;
// a miss refills the whole line from memory, one word per req/done handshake.
//
// state | meaning
// IDLE  | serving lookups; a miss latches the line address and starts a refill
// REQ   | mem_req held high for word cnt until mem_done
// GAP   | one quiet cycle between words, then request word cnt
module icache #(
  parameter int INDEX_BITS = 6,
  parameter int WOFF_BITS  = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_rd_en,
  input  logic [ADDR_W-1:0] if_rd_addr,
  output logic              if_hit,
  output logic [31:0]       if_hit_inst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [31:0]       mem_data
);
  localparam int LINES  = 1 << INDEX_BITS;
  localparam int WORDS  = 1 << WOFF_BITS;
  localparam int TAG_W  = ADDR_W - INDEX_BITS - WOFF_BITS - 2;
  localparam int LINE_W = ADDR_W - WOFF_BITS - 2;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t                state, state_n;
  logic [WOFF_BITS-1:0]  cnt, cnt_n;
  logic [LINE_W-1:0]     line, line_n;
  logic                  req_n;
  logic [ADDR_W-1:0]     addr_n;
  logic                  fill_start, fill_we, fill_last;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES*WORDS];

  logic [WOFF_BITS-1:0]  look_woff;
  logic [INDEX_BITS-1:0] look_idx;
  logic [TAG_W-1:0]      look_tag;
  logic [INDEX_BITS-1:0] line_idx;
  logic [TAG_W-1:0]      line_tag;
  logic                  unused_addr_bits;

  assign look_woff        = if_rd_addr[WOFF_BITS+1:2];
  assign look_idx         = if_rd_addr[INDEX_BITS+WOFF_BITS+1:WOFF_BITS+2];
  assign look_tag         = if_rd_addr[ADDR_W-1:INDEX_BITS+WOFF_BITS+2];
  assign line_idx         = line[INDEX_BITS-1:0];
  assign line_tag         = line[LINE_W-1:INDEX_BITS];
  assign unused_addr_bits = ^if_rd_addr[1:0];

  assign if_hit = if_rd_en && (state == IDLE) && valid[look_idx] && (tag_mem[look_idx] == look_tag);
  // Gated so the word never leaks uninitialised storage on a miss.
  assign if_hit_inst = if_hit ? data_mem[{look_idx, look_woff}] : 32'h0;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    line_n     = line;
    req_n      = mem_req;
    addr_n     = mem_addr;
    fill_start = 1'b0;
    fill_we    = 1'b0;
    fill_last  = 1'b0;
    case (state)
      IDLE: begin
        if (if_rd_en && !if_hit) begin
          line_n     = if_rd_addr[ADDR_W-1:WOFF_BITS+2];
          cnt_n      = '0;
          req_n      = 1'b1;
          addr_n     = {line_n, {WOFF_BITS{1'b0}}, 2'b00};
          fill_start = 1'b1;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (mem_done) begin
          fill_we = 1'b1;
          req_n   = 1'b0;
          if (cnt == {WOFF_BITS{1'b1}}) begin
            fill_last = 1'b1;
            state_n   = IDLE;
          end else begin
            cnt_n   = cnt + 1'b1;
            state_n = GAP;
          end
        end
      end
      GAP: begin
        req_n   = 1'b1;
        addr_n  = {line, cnt, 2'b00};
        state_n = REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  // rdy gates every update, so mem_done is only ever sampled while rdy is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      line     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (rdy) begin
      state    <= state_n;
      cnt      <= cnt_n;
      line     <= line_n;
      mem_req  <= req_n;
      mem_addr <= addr_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (rdy) begin
      if (fill_start) valid[look_idx] <= 1'b0;
      if (fill_last)  valid[line_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && fill_we)   data_mem[{line_idx, cnt}] <= mem_data;
    if (rdy && fill_last) tag_mem[line_idx]         <= line_tag;
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: transaction-level cache/refill model, directed scenarios
// with literal expectations, then randomized lookups, stalls, memory latency and resets.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_rd_en;
  logic [31:0] if_rd_addr;
  logic        if_hit;
  logic [31:0] if_hit_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  always #5 clk = ~clk;

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_rd_en(if_rd_en), .if_rd_addr(if_rd_addr),
    .if_hit(if_hit), .if_hit_inst(if_hit_inst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_data(mem_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_prob = 100;

  // Model: which lines hold which tag, plus progress of the one outstanding refill.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  bit          m_busy, m_req, m_gap;
  int          m_k;
  logic [31:0] m_base;

  logic [31:0] req_log [$];
  bit          log_on = 0;

  // Backing memory contents; one region returns all-zero words.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[7:4] == 4'h7) return 32'h0;
    return 32'h13 + (a >> 2);
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 4) % 64);
  endfunction

  function automatic bit exp_hit();
    int i;
    i = line_of(if_rd_addr);
    return if_rd_en && !m_busy && m_valid[i] && (m_tag[i] == 32'(if_rd_addr >> 10));
  endfunction

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 0;
    m_busy = 0; m_req = 0; m_gap = 0; m_k = 0; m_base = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Called just after a rising edge with rdy/if_* already set; returns just after the next edge.
  task automatic tick();
    bit h;
    int i;
    if (rst) mem_done = 1'b0;
    else if (mem_req) begin
      mem_done = ($urandom_range(0, 99) < done_prob);
      mem_data = mem_word(m_base + 32'(4 * m_k));
    end else begin
      mem_done = ($urandom_range(0, 99) < 15);
      mem_data = $urandom;
    end
    @(negedge clk);
    if (rst) model_clear();
    h = exp_hit();
    chk("if_hit", {31'b0, if_hit}, {31'b0, h});
    if (h) chk("if_hit_inst", if_hit_inst, mem_word({if_rd_addr[31:2], 2'b00}));
    chk("mem_req", {31'b0, mem_req}, {31'b0, m_req});
    if (m_req) chk("mem_addr", mem_addr, m_base + 32'(4 * m_k));
    if (log_on && mem_req) req_log.push_back(mem_addr);
    if (!rst && rdy) begin
      if (!m_busy) begin
        if (if_rd_en && !h) begin
          m_busy = 1; m_req = 1; m_gap = 0; m_k = 0;
          m_base = if_rd_addr & ~32'hF;
          m_valid[line_of(if_rd_addr)] = 0;
        end
      end else if (m_gap) begin
        m_gap = 0; m_req = 1;
      end else if (m_req && mem_done) begin
        m_req = 0;
        m_k++;
        if (m_k == 4) begin
          i = line_of(m_base);
          m_valid[i] = 1;
          m_tag[i]   = 32'(m_base >> 10);
          m_busy = 0; m_k = 0;
        end else m_gap = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mem_done = 1'b0;
    #1;
    model_clear();
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] a);
    if_rd_en = 1'b1;
    if_rd_addr = a;
    #1;
  endtask

  initial begin
    logic [31:0] e1 [4];
    logic [31:0] e4 [3];
    rst = 1'b1; rdy = 1'b1; if_rd_en = 1'b0; if_rd_addr = '0;
    mem_done = 1'b0; mem_data = '0;
    model_clear();
    @(posedge clk); #1;
    apply_reset();

    // Cold miss at 0x0, zero-latency memory
    lookup(32'h0);
    chk("t1_first_hit", {31'b0, if_hit}, 32'h0);
    req_log.delete(); log_on = 1;
    tick();
    chk("t1_req_t1", {31'b0, mem_req}, 32'h1);
    chk("t1_addr_t1", mem_addr, 32'h0);
    ticks(7);
    log_on = 0;
    e1 = '{32'h0, 32'h4, 32'h8, 32'hC};
    chk("t1_nreq", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++) chk("t1_req_addr", req_log[i], e1[i]);
    #1;
    chk("t1_hit", {31'b0, if_hit}, 32'h1);
    chk("t1_inst", if_hit_inst, 32'h00000013);
    tick();

    // Line hit on another word of the same line
    lookup(32'h8);
    chk("t2_hit", {31'b0, if_hit}, 32'h1);
    chk("t2_inst", if_hit_inst, 32'h00000015);
    tick();
    chk("t2_no_req", {31'b0, mem_req}, 32'h0);

    // Conflict on index 0
    lookup(32'h400);
    chk("t3_miss", {31'b0, if_hit}, 32'h0);
    ticks(8);
    lookup(32'h400);
    chk("t3_hit", {31'b0, if_hit}, 32'h1);
    chk("t3_inst", if_hit_inst, 32'h00000113);
    lookup(32'h0);
    chk("t3_evicted", {31'b0, if_hit}, 32'h0);
    tick();
    chk("t3_rereq", {31'b0, mem_req}, 32'h1);
    chk("t3_readdr", mem_addr, 32'h0);
    ticks(7);

    // Fetch address changes after the 2nd mem_done
    lookup(32'h10);
    ticks(4);
    lookup(32'h200);
    req_log.delete(); log_on = 1;
    ticks(6);
    log_on = 0;
    e4 = '{32'h18, 32'h1C, 32'h200};
    chk("t4_nreq", 32'(req_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < req_log.size(); i++) chk("t4_req_addr", req_log[i], e4[i]);
    ticks(6);
    lookup(32'h10);
    chk("t4_hit_old", {31'b0, if_hit}, 32'h1);
    chk("t4_inst_old", if_hit_inst, 32'h00000017);
    lookup(32'h204);
    chk("t4_inst_new", if_hit_inst, 32'h00000094);
    tick();

    // rdy low for 5 cycles while a request is outstanding
    lookup(32'h600);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_req_hold", {31'b0, mem_req}, 32'h1);
      chk("t5_addr_hold", mem_addr, 32'h600);
      tick();
    end
    rdy = 1'b1;
    ticks(8);
    lookup(32'h60C);
    chk("t5_hit", {31'b0, if_hit}, 32'h1);
    chk("t5_inst", if_hit_inst, 32'h00000196);
    lookup(32'h200);
    chk("t5_conflict", {31'b0, if_hit}, 32'h0);
    tick();
    ticks(8);

    // Reset while the refill sits in its gap cycle
    lookup(32'h800);
    ticks(2);
    apply_reset();
    lookup(32'h800);
    chk("t6_miss", {31'b0, if_hit}, 32'h0);
    lookup(32'h0);
    chk("t6_cleared", {31'b0, if_hit}, 32'h0);
    tick();

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) apply_reset();
      rdy = ($urandom_range(0, 99) < 88);
      if_rd_en = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 19) == 0) if_rd_addr = $urandom;
      else if_rd_addr = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 7)) << 4)
                       | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) done_prob = $urandom_range(20, 100);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
